i2s_frame_ctrl: RTL
===================

Name: i2s_frame_ctrl

Overview:
- Serial-clock-domain frame controller for the I2S transceiver.
- Generates word select (ws) and per-bit read/write strobes for the transmit and receive FIFOs, which shift one bit per strobe.
- Supports 16/32-bit words, Philips I2S or left-justified alignment, and graceful stop at a stereo-frame boundary.
- Flags transmit-FIFO underrun and receive-FIFO overrun.

Parameters:
- FIRST_WS, 1'b0, ws level of the first word after start (0 = left channel).
- CNT_W, 16, width of the completed-frame counter (used only with I2S_FRAME_CNT_EN).

Ports:
- sclk  in  1  serial bit clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- frame_32  in  1  0 = 16-bit words, 1 = 32-bit words; latched at start.
- std_lj  in  1  0 = Philips I2S (1-bit delay), 1 = left-justified; latched at start.
- tx_en  in  1  transmit path enabled; latched at start.
- rx_en  in  1  receive path enabled; latched at start.
- tx_empty  in  1  transmit FIFO empty.
- rx_full  in  1  receive FIFO full.
- clr_err  in  1  clears sticky error flags.
- ws  out  1  word select to pad / FIFOs.
- tx_read  out  1  transmit FIFO bit-read strobe.
- rx_write  out  1  receive FIFO bit-write strobe.
- bit_cnt  out  5  current bit index within word, MSB first.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  sticky: a transmit word was skipped.
- overrun  out  1  sticky: a receive word was skipped.

Behaviour:
- Reset (async, any state): state = IDLE; ws = FIRST_WS; tx_read = 0; rx_write = 0; bit_cnt = 0; busy = 0; underrun = 0; overrun = 0; latched config cleared to 0.
- All outputs registered. "Cycle N" means the value after posedge N.
- Word length L = 32 if latched frame_32 else 16. bit_cnt counts L-1 down to 0, then wraps to L-1 (5-bit, never exceeds L-1).
- States: IDLE, LEAD, RUN, DRAIN.
- IDLE:
  - Outputs at reset values.
  - On en=1, latch frame_32, std_lj, tx_en and rx_en.
  - Next state is LEAD if std_lj=0, else RUN with bit_cnt = L-1.
- LEAD (one cycle, Philips only):
  - ws = FIRST_WS; tx_read = rx_write = 0; bit_cnt = L-1.
  - Next state RUN.
- RUN:
  - bit_cnt decrements each cycle.
  - Philips ws timing: ws toggles on the cycle where bit_cnt = 0, so the new ws precedes its MSB by one bit.
  - Left-justified ws timing: ws toggles on the cycle where bit_cnt wraps to L-1.
- Word start is the edge that loads bit_cnt = L-1 inside RUN/DRAIN, including the first word:
  - If tx_en and tx_empty=1 at that edge: tx_read = 0 for the whole word; underrun <= 1.
  - Otherwise tx_read = tx_en for the whole word.
  - rx_write/overrun follow the same rule using rx_en and rx_full.
- Stop:
  - en=0 sampled in RUN -> DRAIN.
  - DRAIN continues until the last bit (bit_cnt = 0) of the word whose ws = !FIRST_WS, then IDLE.
  - ws returns to FIRST_WS on that edge.
  - en=1 during DRAIN is ignored; restart only from IDLE.
- Config inputs changing while busy are ignored.
- clr_err=1 clears both sticky flags.
  - A set event in the same cycle wins over the clear.
- Reset asserted mid-word forces IDLE immediately; no partial-frame completion.

Optional Feature:
- Macro I2S_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [CNT_W-1:0], reset to 0.
  - Increments on the last bit of every !FIRST_WS word, i.e. every completed stereo frame.
  - Wraps modulo 2^CNT_W.
  - Not cleared by stop/start, only by rst.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Philips, 16-bit, tx_en=1, tx_empty=0, en=1 at cycle 0:
  - cycle 1 LEAD with ws=0, tx_read=0.
  - cycles 2–17: tx_read=1, bit_cnt 15..0.
  - ws=1 from cycle 17; ws=0 again at cycle 33.
- Left-justified, 32-bit, rx_en=1, rx_full=0:
  - RUN from cycle 1; ws=0 cycles 1–32, ws=1 cycles 33–64.
  - rx_write=1 throughout; no LEAD cycle.
- Underrun: tx_empty=1 at the start of the second word:
  - tx_read=0 for that full word; underrun=1 and stays set.
  - Next word with tx_empty=0 reads normally.
  - clr_err pulse -> underrun=0.
- Stop: en dropped at bit_cnt=8 of the left word (16-bit):
  - DRAIN completes the right word; IDLE follows its bit_cnt=0.
  - busy=0 and ws=0 after that edge.
  - en=1 during DRAIN has no effect.
- Reset mid-RUN at bit_cnt=5:
  - All outputs at reset values immediately and asynchronously.
  - With en=1 after release, the frame restarts from LEAD.
- With I2S_FRAME_CNT_EN, CNT_W=2:
  - Run 5 stereo frames -> frame_cnt sequence 1,2,3,0,1.
  - Value held through stop and restart.

Source files
------------

// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: word select and per-bit FIFO strobes in the serial-clock domain.
// Define I2S_FRAME_CNT_EN to add the completed-stereo-frame counter output frame_cnt.
module i2s_frame_ctrl #(
    parameter logic FIRST_WS = 1'b0,
    parameter int   CNT_W    = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_32,
    input  logic       std_lj,
    input  logic       tx_en,
    input  logic       rx_en,
    input  logic       tx_empty,
    input  logic       rx_full,
    input  logic       clr_err,
    output logic       ws,
    output logic       tx_read,
    output logic       rx_write,
    output logic [4:0] bit_cnt,
    output logic       busy,
    output logic       underrun,
    output logic       overrun
`ifdef I2S_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RUN, S_DRAIN} state_t;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t     r_state;
    logic       r_f32, r_lj, r_txen, r_rxen;
    logic       r_chan;
    logic       r_ws, r_tx_read, r_rx_write, r_busy, r_underrun, r_overrun;
    logic [4:0] r_bit_cnt;

    logic       w_idle, w_active, w_f32, w_txen, w_rxen;
    logic       w_wrap, w_end, w_start, w_tx_skip, w_rx_skip;
    logic [4:0] w_top;

    // In IDLE the live config applies to the starting edge; afterwards only the latched copy.
    assign w_idle    = (r_state == S_IDLE);
    assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_f32     = w_idle ? frame_32 : r_f32;
    assign w_txen    = w_idle ? tx_en : r_txen;
    assign w_rxen    = w_idle ? rx_en : r_rxen;
    assign w_top     = w_f32 ? 5'd31 : 5'd15;
    assign w_wrap    = w_active && (r_bit_cnt == 5'd0);
    assign w_end     = w_wrap && (r_state == S_DRAIN) && (r_chan != FIRST_WS);
    assign w_start   = (w_idle && en && std_lj) || (r_state == S_LEAD) || (w_wrap && !w_end);
    assign w_tx_skip = w_start && w_txen && tx_empty;
    assign w_rx_skip = w_start && w_rxen && rx_full;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_f32      <= 1'b0;
            r_lj       <= 1'b0;
            r_txen     <= 1'b0;
            r_rxen     <= 1'b0;
            r_chan     <= FIRST_WS;
            r_ws       <= FIRST_WS;
            r_tx_read  <= 1'b0;
            r_rx_write <= 1'b0;
            r_bit_cnt  <= 5'd0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_tx_skip || (r_underrun && !clr_err);
            r_overrun  <= w_rx_skip || (r_overrun && !clr_err);
            if (w_start) begin
                r_tx_read  <= w_txen && !tx_empty;
                r_rx_write <= w_rxen && !rx_full;
            end
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_f32     <= frame_32;
                        r_lj      <= std_lj;
                        r_txen    <= tx_en;
                        r_rxen    <= rx_en;
                        r_bit_cnt <= w_top;
                        r_busy    <= 1'b1;
                        r_chan    <= FIRST_WS;
                        r_state   <= std_lj ? S_RUN : S_LEAD;
                    end
                end
                S_LEAD: begin
                    r_state <= S_RUN;
                    r_chan  <= FIRST_WS;
                end
                S_RUN, S_DRAIN: begin
                    if (w_end) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_bit_cnt  <= 5'd0;
                        r_ws       <= FIRST_WS;
                        r_tx_read  <= 1'b0;
                        r_rx_write <= 1'b0;
                    end else begin
                        if ((r_state == S_RUN) && !en) r_state <= S_DRAIN;
                        // Philips moves ws one bit early; left-justified moves it with the MSB.
                        if (w_wrap) begin
                            r_bit_cnt <= w_top;
                            r_chan    <= ~r_chan;
                            if (r_lj) r_ws <= ~r_chan;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            if (!r_lj && (r_bit_cnt == 5'd1)) r_ws <= ~r_ws;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef I2S_FRAME_CNT_EN
    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_frame_done;

    assign w_frame_done = w_wrap && (r_chan != FIRST_WS);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) r_frame_cnt <= '0;
        else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign ws       = r_ws;
    assign tx_read  = r_tx_read;
    assign rx_write = r_rx_write;
    assign bit_cnt  = r_bit_cnt;
    assign busy     = r_busy;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;

endmodule
